// File: rtl/pipeline_dest_tracker_if.sv
// Bundle between the ID/EX/MEM/WB control path and the destination tracker.
// The tracker drives the stage fields, the pipeline controls and the counters.
interface pipeline_dest_tracker_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  ex_branch_taken;
    logic                  mem_stall;

    logic [REG_ADDR_W-1:0] id_ex_rs1_addr;
    logic [REG_ADDR_W-1:0] id_ex_rs2_addr;
    logic [REG_ADDR_W-1:0] id_ex_rd_addr;
    logic                  id_ex_reg_write;
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_mem_rd_addr;
    logic                  ex_mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_wb_rd_addr;
    logic                  mem_wb_reg_write;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  load_use_hazard;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rd_addr, id_reg_write, id_mem_read, ex_branch_taken, mem_stall,
        input  id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_reg_write,
               id_ex_mem_read, ex_mem_rd_addr, ex_mem_reg_write, mem_wb_rd_addr,
               mem_wb_reg_write, pc_write, if_id_write, if_id_flush,
               load_use_hazard, stall_count, flush_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rd_addr, id_reg_write, id_mem_read, ex_branch_taken, mem_stall,
        output id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_reg_write,
               id_ex_mem_read, ex_mem_rd_addr, ex_mem_reg_write, mem_wb_rd_addr,
               mem_wb_reg_write, pc_write, if_id_write, if_id_flush,
               load_use_hazard, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_dest_tracker.sv
// Destination/control field pipeline for the forwarding unit, plus load-use
// hazard detection and the stall/bubble/flush controls with event counters.
module pipeline_dest_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_dest_tracker_if.slave   trk_if
);
    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } act_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_ADDR_W-1:0] id_ex_rs1_q, id_ex_rs1_d;
    logic [REG_ADDR_W-1:0] id_ex_rs2_q, id_ex_rs2_d;
    logic [REG_ADDR_W-1:0] id_ex_rd_q, id_ex_rd_d;
    logic                  id_ex_wr_q, id_ex_wr_d;
    logic                  id_ex_ld_q, id_ex_ld_d;
    logic [REG_ADDR_W-1:0] ex_mem_rd_q, ex_mem_rd_d;
    logic                  ex_mem_wr_q, ex_mem_wr_d;
    logic [REG_ADDR_W-1:0] mem_wb_rd_q, mem_wb_rd_d;
    logic                  mem_wb_wr_q, mem_wb_wr_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic hazard;
    act_e act;

    assign hazard = id_ex_ld_q && (id_ex_rd_q != '0) &&
                    ((trk_if.id_uses_rs1 && (trk_if.id_rs1_addr == id_ex_rd_q)) ||
                     (trk_if.id_uses_rs2 && (trk_if.id_rs2_addr == id_ex_rd_q)));

    // A taken branch squashes the ID instruction, so it outranks the hazard.
    always_comb begin
        act = ACT_NORMAL;
        if (trk_if.mem_stall)            act = ACT_HOLD;
        else if (trk_if.ex_branch_taken) act = ACT_FLUSH;
        else if (hazard)                 act = ACT_STALL;
    end

    always_comb begin
        id_ex_rs1_d = id_ex_rs1_q;
        id_ex_rs2_d = id_ex_rs2_q;
        id_ex_rd_d  = id_ex_rd_q;
        id_ex_wr_d  = id_ex_wr_q;
        id_ex_ld_d  = id_ex_ld_q;
        ex_mem_rd_d = ex_mem_rd_q;
        ex_mem_wr_d = ex_mem_wr_q;
        mem_wb_rd_d = mem_wb_rd_q;
        mem_wb_wr_d = mem_wb_wr_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        trk_if.pc_write    = 1'b1;
        trk_if.if_id_write = 1'b1;
        trk_if.if_id_flush = 1'b0;

        if (act != ACT_HOLD) begin
            ex_mem_rd_d = id_ex_rd_q;
            ex_mem_wr_d = id_ex_wr_q;
            mem_wb_rd_d = ex_mem_rd_q;
            mem_wb_wr_d = ex_mem_wr_q;
            id_ex_rs1_d = '0;
            id_ex_rs2_d = '0;
            id_ex_rd_d  = '0;
            id_ex_wr_d  = 1'b0;
            id_ex_ld_d  = 1'b0;
        end

        case (act)
            ACT_HOLD: begin
                trk_if.pc_write    = 1'b0;
                trk_if.if_id_write = 1'b0;
            end
            ACT_FLUSH: begin
                trk_if.if_id_flush = 1'b1;
                if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
            ACT_STALL: begin
                trk_if.pc_write    = 1'b0;
                trk_if.if_id_write = 1'b0;
                if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            default: begin
                id_ex_rs1_d = trk_if.id_rs1_addr;
                id_ex_rs2_d = trk_if.id_rs2_addr;
                id_ex_rd_d  = trk_if.id_rd_addr;
                // x0 is never a writing destination downstream.
                id_ex_wr_d  = trk_if.id_reg_write && (trk_if.id_rd_addr != '0);
                id_ex_ld_d  = trk_if.id_mem_read;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_rs1_q <= '0;
            id_ex_rs2_q <= '0;
            id_ex_rd_q  <= '0;
            id_ex_wr_q  <= 1'b0;
            id_ex_ld_q  <= 1'b0;
            ex_mem_rd_q <= '0;
            ex_mem_wr_q <= 1'b0;
            mem_wb_rd_q <= '0;
            mem_wb_wr_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_ex_rs1_q <= id_ex_rs1_d;
            id_ex_rs2_q <= id_ex_rs2_d;
            id_ex_rd_q  <= id_ex_rd_d;
            id_ex_wr_q  <= id_ex_wr_d;
            id_ex_ld_q  <= id_ex_ld_d;
            ex_mem_rd_q <= ex_mem_rd_d;
            ex_mem_wr_q <= ex_mem_wr_d;
            mem_wb_rd_q <= mem_wb_rd_d;
            mem_wb_wr_q <= mem_wb_wr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign trk_if.id_ex_rs1_addr   = id_ex_rs1_q;
    assign trk_if.id_ex_rs2_addr   = id_ex_rs2_q;
    assign trk_if.id_ex_rd_addr    = id_ex_rd_q;
    assign trk_if.id_ex_reg_write  = id_ex_wr_q;
    assign trk_if.id_ex_mem_read   = id_ex_ld_q;
    assign trk_if.ex_mem_rd_addr   = ex_mem_rd_q;
    assign trk_if.ex_mem_reg_write = ex_mem_wr_q;
    assign trk_if.mem_wb_rd_addr   = mem_wb_rd_q;
    assign trk_if.mem_wb_reg_write = mem_wb_wr_q;
    assign trk_if.load_use_hazard  = hazard;
    assign trk_if.stall_count      = stall_cnt_q;
    assign trk_if.flush_count      = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_dest_tracker.sv
// Directed bench for pipeline_dest_tracker; a second instance with 2-bit
// counters sees identical stimulus to exercise counter saturation.
module tb_pipeline_dest_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks_cnt = 0;
    int   fail_cnt   = 0;

    always #5 clk = ~clk;

    pipeline_dest_tracker_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_m ();
    pipeline_dest_tracker_if #(.REG_ADDR_W(5), .CNT_W(2))  bus_s ();

    pipeline_dest_tracker #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .trk_if(bus_m.slave));
    pipeline_dest_tracker #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .trk_if(bus_s.slave));

    assign bus_s.id_rs1_addr     = bus_m.id_rs1_addr;
    assign bus_s.id_rs2_addr     = bus_m.id_rs2_addr;
    assign bus_s.id_uses_rs1     = bus_m.id_uses_rs1;
    assign bus_s.id_uses_rs2     = bus_m.id_uses_rs2;
    assign bus_s.id_rd_addr      = bus_m.id_rd_addr;
    assign bus_s.id_reg_write    = bus_m.id_reg_write;
    assign bus_s.id_mem_read     = bus_m.id_mem_read;
    assign bus_s.ex_branch_taken = bus_m.ex_branch_taken;
    assign bus_s.mem_stall       = bus_m.mem_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd, input logic wr,
                            input logic ld);
        bus_m.id_rs1_addr  = rs1;
        bus_m.id_uses_rs1  = u1;
        bus_m.id_rs2_addr  = rs2;
        bus_m.id_uses_rs2  = u2;
        bus_m.id_rd_addr   = rd;
        bus_m.id_reg_write = wr;
        bus_m.id_mem_read  = ld;
        #1;
    endtask

    task automatic chk_stages(input string tag, input int ie_rd, input int ie_wr,
                              input int em_rd, input int em_wr,
                              input int mw_rd, input int mw_wr);
        chk({tag, ".id_ex_rd"},  32'(bus_m.id_ex_rd_addr),    ie_rd);
        chk({tag, ".id_ex_wr"},  32'(bus_m.id_ex_reg_write),  ie_wr);
        chk({tag, ".ex_mem_rd"}, 32'(bus_m.ex_mem_rd_addr),   em_rd);
        chk({tag, ".ex_mem_wr"}, 32'(bus_m.ex_mem_reg_write), em_wr);
        chk({tag, ".mem_wb_rd"}, 32'(bus_m.mem_wb_rd_addr),   mw_rd);
        chk({tag, ".mem_wb_wr"}, 32'(bus_m.mem_wb_reg_write), mw_wr);
    endtask

    task automatic chk_ctrl(input string tag, input int haz, input int pcw,
                            input int ifw, input int ifl);
        chk({tag, ".hazard"},      32'(bus_m.load_use_hazard), haz);
        chk({tag, ".pc_write"},    32'(bus_m.pc_write),        pcw);
        chk({tag, ".if_id_write"}, 32'(bus_m.if_id_write),     ifw);
        chk({tag, ".if_id_flush"}, 32'(bus_m.if_id_flush),     ifl);
    endtask

    initial begin
        bus_m.ex_branch_taken = 1'b0;
        bus_m.mem_stall       = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_stages("rst", 0, 0, 0, 0, 0, 0);
        chk("rst.id_ex_ld", 32'(bus_m.id_ex_mem_read), 0);
        chk("rst.stall_cnt", 32'(bus_m.stall_count), 0);
        chk("rst.flush_cnt", 32'(bus_m.flush_count), 0);
        chk_ctrl("rst", 0, 1, 1, 0);
        rst = 1'b0;

        // Normal flow: rd=3 reaches EX/MEM after 2 edges, MEM/WB after 3
        drive_id(1, 1, 2, 1, 3, 1, 0);
        chk_ctrl("norm", 0, 1, 1, 0);
        tick();
        chk("norm.id_ex_rs1", 32'(bus_m.id_ex_rs1_addr), 1);
        chk("norm.id_ex_rs2", 32'(bus_m.id_ex_rs2_addr), 2);
        chk_stages("norm.e1", 3, 1, 0, 0, 0, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_stages("norm.e2", 0, 0, 3, 1, 0, 0);
        tick();
        chk_stages("norm.e3", 0, 0, 0, 0, 3, 1);

        // Load-use on rs1
        drive_id(0, 0, 0, 0, 5, 1, 1);
        tick();
        chk("lu.id_ex_ld", 32'(bus_m.id_ex_mem_read), 1);
        drive_id(5, 1, 0, 0, 6, 1, 0);
        chk_ctrl("lu", 1, 0, 0, 0);
        tick();
        chk_stages("lu.bubble", 0, 0, 5, 1, 0, 0);
        chk("lu.stall_cnt", 32'(bus_m.stall_count), 1);
        chk_ctrl("lu.after", 0, 1, 1, 0);
        tick();
        chk_stages("lu.resume", 6, 1, 0, 0, 5, 1);
        chk("lu.resume.rs1", 32'(bus_m.id_ex_rs1_addr), 5);

        // Matching address but not used -> no hazard; rs2 used -> hazard
        drive_id(0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(5, 0, 5, 0, 0, 0, 0);
        chk("nouse.hazard", 32'(bus_m.load_use_hazard), 0);
        drive_id(0, 0, 5, 1, 0, 0, 0);
        chk("rs2.hazard", 32'(bus_m.load_use_hazard), 1);
        drive_id(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Load to x0: reg_write normalised away and no hazard
        drive_id(0, 0, 0, 0, 0, 1, 1);
        tick();
        chk("x0.id_ex_wr", 32'(bus_m.id_ex_reg_write), 0);
        chk("x0.id_ex_ld", 32'(bus_m.id_ex_mem_read), 1);
        drive_id(0, 1, 0, 1, 0, 0, 0);
        chk("x0.hazard", 32'(bus_m.load_use_hazard), 0);
        drive_id(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Branch flush with coincident load-use
        drive_id(0, 0, 0, 0, 7, 1, 1);
        tick();
        drive_id(7, 1, 0, 0, 8, 1, 0);
        bus_m.ex_branch_taken = 1'b1;
        #1;
        chk_ctrl("br", 1, 1, 1, 1);
        tick();
        bus_m.ex_branch_taken = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0);
        chk("br.id_ex_rd", 32'(bus_m.id_ex_rd_addr), 0);
        chk("br.id_ex_ld", 32'(bus_m.id_ex_mem_read), 0);
        chk("br.ex_mem_rd", 32'(bus_m.ex_mem_rd_addr), 7);
        chk("br.flush_cnt", 32'(bus_m.flush_count), 1);
        chk("br.stall_cnt", 32'(bus_m.stall_count), 1);

        // mem_stall held 3 cycles over populated stages
        drive_id(0, 0, 0, 0, 10, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 11, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 12, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 13, 1, 0);
        bus_m.mem_stall = 1'b1;
        #1;
        chk_ctrl("ms", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_stages($sformatf("ms.c%0d", i), 12, 1, 11, 1, 10, 1);
            chk($sformatf("ms.c%0d.stall_cnt", i), 32'(bus_m.stall_count), 1);
            chk($sformatf("ms.c%0d.flush_cnt", i), 32'(bus_m.flush_count), 1);
        end
        bus_m.mem_stall = 1'b0;
        #1;
        tick();
        chk_stages("ms.release", 13, 1, 12, 1, 11, 1);

        // Five more load-use hazards: 6 total, 2-bit counter saturates at 3
        chk("sat.pre", 32'(bus_s.stall_count), 1);
        for (int i = 0; i < 5; i++) begin
            drive_id(0, 0, 0, 0, 9, 1, 1);
            tick();
            drive_id(0, 0, 9, 1, 0, 0, 0);
            tick();
        end
        chk("sat.main_cnt", 32'(bus_m.stall_count), 6);
        chk("sat.small_cnt", 32'(bus_s.stall_count), 3);
        chk("sat.small_flush", 32'(bus_s.flush_count), 1);

        // Asynchronous reset in the middle of a stall
        drive_id(0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(5, 1, 0, 0, 0, 0, 0);
        chk("arst.pre_hazard", 32'(bus_m.load_use_hazard), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_stages("arst", 0, 0, 0, 0, 0, 0);
        chk("arst.stall_cnt", 32'(bus_m.stall_count), 0);
        chk("arst.flush_cnt", 32'(bus_m.flush_count), 0);
        chk_ctrl("arst", 0, 1, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        drive_id(0, 0, 0, 0, 20, 1, 0);
        tick();
        chk_stages("arst.first", 20, 1, 0, 0, 0, 0);
        chk("arst.first.stall_cnt", 32'(bus_m.stall_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end
endmodule
